// File: rtl/generic_dpram_sc_if.sv
// Bus bundle for the single-clock simple dual-port RAM.
// master drives addresses/enables/data; slave returns dout.
interface generic_dpram_sc_if #(
    parameter int aw = 5,
    parameter int dw = 16
);
    logic          rce;
    logic          oe;
    logic [aw-1:0] raddr;
    logic [dw-1:0] dout;
    logic          wce;
    logic          we;
    logic [aw-1:0] waddr;
    logic [dw-1:0] di;

    modport master (
        output rce, oe, raddr, wce, we, waddr, di,
        input  dout
    );

    modport slave (
        input  rce, oe, raddr, wce, we, waddr, di,
        output dout
    );
endinterface

// File: rtl/generic_dpram_sc.sv
// Single-clock simple dual-port RAM, registered read address.
// GENERIC_DPRAM_TRISTATE_EN: dout floats (Z) when oe=0, else 0.
module generic_dpram_sc #(
    parameter int aw = 5,
    parameter int dw = 16
) (
    input logic               clk,
    input logic               rst,
    generic_dpram_sc_if.slave bus
);
    localparam int DEPTH = 2 ** aw;

    logic [dw-1:0] r_mem [DEPTH];
    logic [aw-1:0] r_ra;
    logic [dw-1:0] w_rdata;

    // Array write; reset never touches the contents
    always_ff @(posedge clk) begin
        if (bus.wce && bus.we) begin
            r_mem[bus.waddr] <= bus.di;
        end
    end

    // Read address register, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra <= '0;
        end else if (bus.rce) begin
            r_ra <= bus.raddr;
        end
    end

    // Combinational read: a write to mem[ra] shows on the next cycle's dout
    assign w_rdata = r_mem[r_ra];

`ifdef GENERIC_DPRAM_TRISTATE_EN
    assign bus.dout = bus.oe ? w_rdata : {dw{1'bz}};
`else
    assign bus.dout = bus.oe ? w_rdata : {dw{1'b0}};
`endif

endmodule

// File: tb/tb_generic_dpram_sc.sv
// Directed self-checking bench for generic_dpram_sc (aw=5, dw=16).
// Linear stimulus with immediate assertions at each check point.
module tb_generic_dpram_sc;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef GENERIC_DPRAM_TRISTATE_EN
    localparam logic [15:0] DIS = 16'hzzzz;
`else
    localparam logic [15:0] DIS = 16'h0000;
`endif

    generic_dpram_sc_if #(.aw(5), .dw(16)) bus ();

    generic_dpram_sc #(.aw(5), .dw(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.rce = 1'b0;
        bus.oe = 1'b0;
        bus.raddr = '0;
        bus.wce = 1'b0;
        bus.we = 1'b0;
        bus.waddr = '0;
        bus.di = '0;
        #1 check("rst_oe0", bus.dout, DIS);
        bus.oe = 1'b1;

        // write accepted during reset; raddr capture blocked by reset
        bus.wce = 1'b1; bus.we = 1'b1;
        bus.waddr = 5'd0; bus.di = 16'hBEEF;
        bus.rce = 1'b1; bus.raddr = 5'd5;
        @(posedge clk); #1 check("rst_write", bus.dout, 16'hBEEF);

        // basic write then read, one-cycle latency
        @(negedge clk);
        rst = 1'b0;
        bus.waddr = 5'd3; bus.di = 16'hA5A5; bus.rce = 1'b0;
        @(posedge clk); #1 check("ra_hold0", bus.dout, 16'hBEEF);
        @(negedge clk);
        bus.wce = 1'b0; bus.we = 1'b0;
        bus.raddr = 5'd3; bus.rce = 1'b1;
        #1 check("pre_edge", bus.dout, 16'hBEEF);
        @(posedge clk); #1 check("rd3", bus.dout, 16'hA5A5);

        // write gating on address 7
        @(negedge clk);
        bus.rce = 1'b0;
        bus.wce = 1'b1; bus.we = 1'b1;
        bus.waddr = 5'd7; bus.di = 16'h1111;
        @(negedge clk);
        bus.wce = 1'b0; bus.we = 1'b0;
        bus.raddr = 5'd7; bus.rce = 1'b1;
        @(posedge clk); #1 check("rd7", bus.dout, 16'h1111);
        @(negedge clk);
        bus.rce = 1'b0;
        bus.wce = 1'b0; bus.we = 1'b1; bus.di = 16'h2222;
        @(posedge clk); #1 check("gate_wce", bus.dout, 16'h1111);
        @(negedge clk);
        bus.wce = 1'b1; bus.we = 1'b0; bus.di = 16'h3333;
        @(posedge clk); #1 check("gate_we", bus.dout, 16'h1111);

        // rce hold
        @(negedge clk);
        bus.wce = 1'b0;
        bus.raddr = 5'd3; bus.rce = 1'b1;
        @(posedge clk); #1 check("hold_cap", bus.dout, 16'hA5A5);
        @(negedge clk);
        bus.rce = 1'b0; bus.raddr = 5'd7;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 check("rce_hold", bus.dout, 16'hA5A5);
        end

        // write-first collision on address 9
        @(negedge clk);
        bus.wce = 1'b1; bus.we = 1'b1;
        bus.waddr = 5'd9; bus.di = 16'h0000;
        @(negedge clk);
        bus.raddr = 5'd9; bus.rce = 1'b1; bus.di = 16'h5A5A;
        @(posedge clk); #1 check("collide", bus.dout, 16'h5A5A);

        // write to the address ra already points at
        @(negedge clk);
        bus.rce = 1'b0; bus.di = 16'h1234;
        @(posedge clk); #1 check("wr_under_ra", bus.dout, 16'h1234);

        // full sweep: data = address
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.wce = 1'b1; bus.we = 1'b1;
            bus.waddr = 5'(i); bus.di = 16'(i);
        end
        @(negedge clk);
        bus.wce = 1'b0; bus.we = 1'b0;

        // read back, with an asynchronous reset pulse mid-sweep
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.raddr = 5'(i); bus.rce = 1'b1;
            if (i == 16) begin
                #1 rst = 1'b1;
                #1 check("rst_async", bus.dout, 16'h0000);
                #1 rst = 1'b0;
            end
            @(posedge clk); #1 check("sweep", bus.dout, 16'(i));
        end

        // reset after pointing at 31, then oe=0
        @(negedge clk);
        bus.rce = 1'b0;
        #1 rst = 1'b1;
        #1 check("rst_ra0", bus.dout, 16'h0000);
        bus.oe = 1'b0;
        #1 check("oe0", bus.dout, DIS);
        bus.oe = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // contents survive reset
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.raddr = 5'(i); bus.rce = 1'b1;
            @(posedge clk); #1 check("keep", bus.dout, 16'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/generic_dpram_sc.md
Name: generic_dpram_sc

Overview:
- Single-clock, simple dual-port RAM: one write port, one read port, depth 2^aw words of dw bits.
- Used as the storage array behind the synchronous FIFO. The FIFO drives the write port from its write pointer and the read port from its read pointer.
- The read address is registered and the read data is combinational from that registered address. Read data therefore appears one cycle after the address is presented.

Parameters:
- aw, 5, address width; depth = 2^aw words; first positional parameter.
- dw, 16, data width in bits; second positional parameter.

Ports:
- clk  input  1  single clock for both ports; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rce  input  1  read clock enable; when high, raddr is captured on the clock edge.
- oe  input  1  output enable for dout.
- raddr  input  aw  read address.
- dout  output  dw  read data = mem[ra], where ra is the registered read address.
- wce  input  1  write clock enable.
- we  input  1  write enable; a write occurs only when wce and we are both high.
- waddr  input  aw  write address.
- di  input  dw  write data.

Behaviour:
- Storage: array mem[0 .. 2^aw-1] of dw bits. Reset does not clear the array; contents are undefined until written.
- Read address register ra, aw bits:
  - rst high: ra is forced to 0 immediately, asynchronously, without waiting for a clock edge.
  - Otherwise, on the clk rising edge: if rce=1 then ra <= raddr; if rce=0, ra holds.
- Read data: dout = mem[ra], combinational from ra and the array. This gives one-cycle read latency from raddr.
  - Changes to mem[ra] become visible on dout right after the write edge, with no extra cycle.
- Reset value of dout: mem[0]. If oe=0, dout takes the disabled value defined under Optional Feature.
- Write: on the clk rising edge, if wce=1 and we=1, then mem[waddr] <= di. If either is 0, no write.
  - Writes are accepted while rst is high; reset affects only ra.
- Same-cycle write and read-address capture, with waddr == raddr:
  - The edge writes di and captures ra = raddr.
  - dout shows the new di after that edge (write-first).
- Read of an address being written while ra already points to it: dout changes to the new data right after the write edge.
- Address wrap: addresses are aw bits with no range check; every value 0 .. 2^aw-1 is valid.
- No full/empty logic, no handshake and no error flags; sequencing is the caller's responsibility.
- Reset asserted mid-operation:
  - ra goes to 0 at once and dout shows mem[0].
  - Array contents written earlier are preserved.

Optional Feature:
- Macro: GENERIC_DPRAM_TRISTATE_EN.
- Defined: when oe=0, dout is high-impedance (all bits Z), for sharing a bus.
- Undefined (default): when oe=0, dout is driven to all zeros, so no tristate buffers are inferred.
- In both builds, when oe=1, dout = mem[ra].

Test Plan:
- Reset: assert rst with no clock edge -> ra=0 immediately; dout = mem[0].
- Basic write/read (aw=5, dw=16):
  - Write 0xA5A5 to address 3 with wce=1, we=1.
  - Next cycle present raddr=3 with rce=1.
  - Response: dout=0xA5A5 after that edge, not before.
- Write gating:
  - Write 0x1111 to address 7, then drive we=1, wce=0 with di=0x2222 to address 7.
  - Response: read of address 7 returns 0x1111; same result with wce=1, we=0.
- Write-first collision:
  - Same edge: waddr=raddr=9, di=0x5A5A, rce=1, with mem[9]=0x0000 beforehand.
  - Response: dout=0x5A5A right after the edge.
- rce hold:
  - Capture raddr=3 (holding 0xA5A5), then drive rce=0 and raddr=7.
  - Response: dout stays 0xA5A5 over 3 edges.
- Full address sweep and reset preservation:
  - Write data=address to all 32 locations, read them back, assert rst mid-sweep.
  - Response: every read matches; after reset, contents are unchanged and ra=0.
  - With oe=0, dout=0x0000, or Z in the GENERIC_DPRAM_TRISTATE_EN build.
